pipe_rate_pwr_ctrl: RTL
=======================

Name: pipe_rate_pwr_ctrl

Overview:
- MAC-side controller for multi-lane PIPE rate and power-state changes. Sits between the LTSSM and the PIPE lane signals.
- Drives the shared `rate` and `power_down` to all lanes. Waits for every lane's `phy_status` completion pulse, with a timeout.
- Gates `tx_elec_idle` for the duration of a transition.
- Generalises the single-lane PIPE signal set to NUM_LANES lanes and adds a request/done handshake.

Parameters:
- NUM_LANES, 4, number of PIPE lanes handled (1..16)
- TIMEOUT_CYCLES, 1024, clk cycles to wait for all phy_status pulses before flagging an error
- RATE_W, 4, width of the rate field
- PD_W, 4, width of the power_down field

Ports:
- clk  input  1  PIPE PCLK-domain clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  LTSSM requests a rate/power change
- req_ready  output  1  controller can accept a request
- req_rate  input  RATE_W  requested rate (0=Gen1 .. 4=Gen5)
- req_power_down  input  PD_W  requested state (0=P0, 1=P0s, 2=P1, 3=P2)
- done  output  1  one-cycle pulse: change completed on all lanes
- err_timeout  output  1  one-cycle pulse: not all lanes responded within TIMEOUT_CYCLES
- err_illegal  output  1  one-cycle pulse: request rejected
- busy  output  1  transition in progress
- mac_tx_elec_idle  input  NUM_LANES  per-lane electrical-idle request from the MAC
- phy_status  input  NUM_LANES  per-lane PHY completion pulses
- rate  output  RATE_W  rate to all lanes
- power_down  output  PD_W  power state to all lanes
- tx_elec_idle  output  NUM_LANES  per-lane electrical-idle to the PHY

Behaviour:
- Reset values:
  - rate = 0, power_down = 2 (P1), tx_elec_idle = all 1
  - req_ready = 0, busy = 1
  - done, err_timeout, err_illegal = 0
  - FSM = INIT
- States:
  - INIT: stay until phy_status == 0 on all lanes for one cycle, then go to IDLE. This is the PHY reset-complete indication.
  - IDLE: req_ready = 1, busy = 0.
    - On req_valid && req_ready in cycle T, check the request.
    - If req_rate != rate and req_power_down is not P0 or P1, pulse err_illegal at T+1, stay in IDLE, outputs unchanged.
    - Else, if req_rate == rate and req_power_down == power_down (no-op), pulse done at T+1, stay in IDLE.
    - Else, register the new rate and power_down (visible at T+1), clear the sticky lane capture, clear the timer, go to WAIT.
  - WAIT: req_ready = 0, busy = 1.
    - Sample phy_status from T+2 onward. Each lane's bit is captured stickily.
    - When all lanes are captured in cycle C, pulse done at C+1 and return to IDLE.
    - The timer increments each WAIT cycle. When it reaches TIMEOUT_CYCLES, pulse err_timeout and return to IDLE. The new rate and power_down are retained.
- Simultaneous events: if the final capture and the timeout occur in the same cycle, completion wins (done, not err_timeout).
- phy_status pulses in IDLE are ignored.
- A phy_status held high longer than one cycle counts once.
- Timer width is $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.
- tx_elec_idle[i] = 1 in each of these cases, otherwise mac_tx_elec_idle[i] (registered, 1-cycle latency):
  - busy,
  - power_down != P0,
  - mac_tx_elec_idle[i] = 1.
- Reset mid-operation returns to INIT with the reset values above. A pending request is dropped silently.
- Only one request is outstanding at a time; req_valid while req_ready = 0 is ignored (not queued).

Optional Feature:
- Macro: PIPE_LANE_MASK_EN
- Defined: adds input lane_active [NUM_LANES-1:0], sampled at request acceptance.
  - Only active lanes must report phy_status; inactive lanes are pre-set as captured.
  - Inactive lanes drive tx_elec_idle = 1 permanently.
  - lane_active == 0 at acceptance: done at T+1 with no WAIT.
- Undefined: all lanes are always required; the port does not exist.

Decomposition:
- Shared package pipe_pkg holds:
  - pipe_pwr_e enum (P0, P0S, P1, P2)
  - pipe_rate_e enum (GEN1..GEN5)
  - ctrl_state_e FSM typedef (INIT, IDLE, WAIT)
  - constant PIPE_RESET_PD = P1
- Sub-module pipe_status_collector:
  - parametrised by NUM_LANES
  - sticky per-lane capture with clear and preset-mask inputs
  - all_captured output

Test Plan:
- Reset released with phy_status = 4'hF, dropped to 0 five cycles later -> req_ready rises the cycle after phy_status reaches 0; rate = 0, power_down = 2, tx_elec_idle = 4'hF.
- Request rate 2 with P0 from IDLE; lanes pulse phy_status at T+3, T+4, T+4, T+7 -> rate = 2 from T+1; done at T+8; tx_elec_idle = 4'hF throughout; err_timeout never asserted.
- Request rate 1 with power_down P2 -> err_illegal at T+1; rate, power_down and req_ready unchanged.
- TIMEOUT_CYCLES = 16, lane 3 never pulses -> err_timeout 16 WAIT cycles after entry; new values kept; next request accepted.
- Last lane pulses on the same cycle the timer expires -> done = 1, err_timeout = 0.
- Assert reset mid-WAIT -> next cycle rate = 0, power_down = 2, FSM in INIT; no done or err pulse.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared PIPE rate/power encodings and controller state type
package pipe_pkg;

    typedef enum logic [3:0] {
        P0  = 4'd0,
        P0S = 4'd1,
        P1  = 4'd2,
        P2  = 4'd3
    } pipe_pwr_e;

    typedef enum logic [3:0] {
        GEN1 = 4'd0,
        GEN2 = 4'd1,
        GEN3 = 4'd2,
        GEN4 = 4'd3,
        GEN5 = 4'd4
    } pipe_rate_e;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2
    } ctrl_state_e;

    localparam pipe_pwr_e PIPE_RESET_PD = P1;

endpackage

// File: rtl/pipe_status_collector.sv
// rtl/pipe_status_collector.sv - sticky per-lane phy_status capture with preset mask
module pipe_status_collector #(
    parameter int NUM_LANES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 sample_en,
    input  logic [NUM_LANES-1:0] preset_mask,
    input  logic [NUM_LANES-1:0] status,
    output logic                 all_captured
);

    logic [NUM_LANES-1:0] cap_q;
    logic [NUM_LANES-1:0] cap_d;
    logic [NUM_LANES-1:0] hits;

    always_comb begin
        hits  = sample_en ? status : '0;
        cap_d = clear ? preset_mask : (cap_q | hits);
    end

    // Includes this cycle's hits so the final pulse completes without an extra cycle.
    assign all_captured = &(cap_q | hits);

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

endmodule

// File: rtl/pipe_rate_pwr_ctrl.sv
// rtl/pipe_rate_pwr_ctrl.sv - multi-lane PIPE rate/power change controller (optional PIPE_LANE_MASK_EN)
module pipe_rate_pwr_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int RATE_W         = 4,
    parameter int PD_W           = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [RATE_W-1:0]    req_rate,
    input  logic [PD_W-1:0]      req_power_down,
    output logic                 done,
    output logic                 err_timeout,
    output logic                 err_illegal,
    output logic                 busy,
`ifdef PIPE_LANE_MASK_EN
    input  logic [NUM_LANES-1:0] lane_active,
`endif
    input  logic [NUM_LANES-1:0] mac_tx_elec_idle,
    input  logic [NUM_LANES-1:0] phy_status,
    output logic [RATE_W-1:0]    rate,
    output logic [PD_W-1:0]      power_down,
    output logic [NUM_LANES-1:0] tx_elec_idle
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);

    ctrl_state_e          state_q, state_d;
    logic [RATE_W-1:0]    rate_q, rate_d;
    logic [PD_W-1:0]      pd_q, pd_d;
    logic [NUM_LANES-1:0] tx_ei_q, tx_ei_d;
    logic [NUM_LANES-1:0] active_q, active_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 done_q, done_d;
    logic                 err_to_q, err_to_d;
    logic                 err_il_q, err_il_d;

    logic [NUM_LANES-1:0] req_mask;
    logic                 coll_clear;
    logic                 sample_en;
    logic                 all_captured;
    logic                 pd_is_legal_for_rate;

`ifdef PIPE_LANE_MASK_EN
    assign req_mask = lane_active;
`else
    assign req_mask = '1;
`endif

    // The first WAIT cycle is skipped so pulses tied to the old rate are not counted.
    assign sample_en = (state_q == WAIT) && (timer_q != '0);

    pipe_status_collector #(
        .NUM_LANES (NUM_LANES)
    ) u_collector (
        .clk          (clk),
        .reset        (reset),
        .clear        (coll_clear),
        .sample_en    (sample_en),
        .preset_mask  (~req_mask),
        .status       (phy_status),
        .all_captured (all_captured)
    );

    assign pd_is_legal_for_rate = (req_power_down == PD_W'(P0)) || (req_power_down == PD_W'(P1));

    always_comb begin
        state_d    = state_q;
        rate_d     = rate_q;
        pd_d       = pd_q;
        active_d   = active_q;
        timer_d    = timer_q;
        done_d     = 1'b0;
        err_to_d   = 1'b0;
        err_il_d   = 1'b0;
        coll_clear = 1'b0;

        case (state_q)
            INIT: begin
                if (phy_status == '0) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    if ((req_rate != rate_q) && !pd_is_legal_for_rate) begin
                        err_il_d = 1'b1;
                    end else if ((req_rate == rate_q) && (req_power_down == pd_q)) begin
                        done_d = 1'b1;
                    end else begin
                        rate_d     = req_rate;
                        pd_d       = req_power_down;
                        active_d   = req_mask;
                        coll_clear = 1'b1;
                        timer_d    = '0;
                        if (req_mask == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
                if (all_captured) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timer_q >= TIMER_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = INIT;
        endcase

        tx_ei_d = {NUM_LANES{(state_q != IDLE) || (pd_q != PD_W'(P0))}}
                | mac_tx_elec_idle | ~active_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= INIT;
            rate_q   <= RATE_W'(GEN1);
            pd_q     <= PD_W'(PIPE_RESET_PD);
            tx_ei_q  <= '1;
            active_q <= '1;
            timer_q  <= '0;
            done_q   <= 1'b0;
            err_to_q <= 1'b0;
            err_il_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rate_q   <= rate_d;
            pd_q     <= pd_d;
            tx_ei_q  <= tx_ei_d;
            active_q <= active_d;
            timer_q  <= timer_d;
            done_q   <= done_d;
            err_to_q <= err_to_d;
            err_il_q <= err_il_d;
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign err_timeout  = err_to_q;
    assign err_illegal  = err_il_q;
    assign rate         = rate_q;
    assign power_down   = pd_q;
    assign tx_elec_idle = tx_ei_q;

endmodule
